adc_sar_ctrl_12bit: RTL

// - Synchronous 12-bit SAR controller that drives the 12-bit capacitor-array matrix
//   (sample/switch controls, row/col thermometer decode, binary LSB enables) and reads its comparator.
// - Upper 9 code bits drive 512 unit cells as a 16x32 thermometer matrix.
// - Lower 3 bits drive the binary sub-unit caps through en_bit_n.
// - Sits between the digital ADC front-end (start/result handshake) and the analog array macro.

---
 rtl/adc_sar_ctrl_12bit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/adc_sar_ctrl_12bit.sv
// 12-bit SAR conversion controller for the segmented capacitor array.
// The upper 9 code bits drive a 16x32 thermometer matrix of unit cells and
// the lower 3 bits drive binary sub-unit caps. All array-facing controls
// come from flops.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start, array parked at code 0, terminating cap off
// ST_SAMPLE  | top plate tied to vcm, input tracked for SAMPLE_CYCLES cycles
// ST_CONVERT | one trial per bit (11..0), each held SETTLE_CYCLES cycles
// ST_DONE    | single cycle: result loaded, done pulsed, busy still high
module adc_sar_ctrl_12bit #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        comp_in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] result_o,
  output logic        sample_o,
  output logic        sample_n_o,
  output logic        sw_o,
  output logic        sw_n_o,
  output logic [15:0] row_n_o,
  output logic [15:0] rowon_n_o,
  output logic [15:0] rowoff_n_o,
  output logic [31:0] col_n_o,
  output logic [31:0] col_o,
  output logic [2:0]  en_bit_n_o,
  output logic        en_C0_n_o
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_CONVERT, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [11:0]     code_q, code_d;
  logic [11:0]     result_q, result_d;
  logic [11:0]     kept;
  logic            done_d;

  logic            busy_q, done_q, sample_q, en_c0_n_q;
  logic [15:0]     row_n_q, rowon_n_q, rowoff_n_q;
  logic [15:0]     row_n_d, rowon_n_d, rowoff_n_d;
  logic [31:0]     col_n_q, col_n_d;
  logic [2:0]      en_bit_n_q;

  logic [8:0]      unit_d;
  logic [3:0]      row_sel;
  logic [4:0]      col_sel;

  // Sequencing: next state, settle/sample countdown, trial code and result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;
    done_d   = 1'b0;
    kept     = code_q;
    case (state_q)
      ST_IDLE: begin
        code_d = '0;
        if (start_i) begin
          state_d = ST_SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
        end
      end
      ST_SAMPLE: begin
        code_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_CONVERT;
          bit_d   = 4'd11;
          code_d  = 12'h800;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CONVERT: begin
        if (cnt_q == '0) begin
          // comparator only matters on the last settle cycle of a trial
          kept = comp_in_i ? code_q : (code_q & ~(12'(1) << bit_q));
          if (bit_q == 4'd0) begin
            state_d  = ST_DONE;
            code_d   = kept;
            result_d = kept;
            done_d   = 1'b1;
          end else begin
            bit_d  = bit_q - 4'd1;
            code_d = kept | (12'(1) << (bit_q - 4'd1));
            cnt_d  = CW'(SETTLE_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = '0;
      end
    endcase
  end

  // Thermometer decode of the next code into row/column line levels.
  always_comb begin
    unit_d     = code_d[11:3];
    row_sel    = unit_d[8:5];
    col_sel    = unit_d[4:0];
    row_n_d    = '1;
    rowon_n_d  = '1;
    rowoff_n_d = '1;
    col_n_d    = '1;
    for (int r = 0; r < 16; r++) begin
      rowon_n_d[r]  = !(4'(r) < row_sel);
      rowoff_n_d[r] = !((4'(r) > row_sel) || ((4'(r) == row_sel) && (col_sel == 5'd0)));
      row_n_d[r]    = !((4'(r) == row_sel) && (col_sel != 5'd0));
    end
    for (int c = 0; c < 32; c++) begin
      col_n_d[c] = !(5'(c) < col_sel);
    end
  end

  // State and registered array controls; synchronous reset parks everything at code 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      code_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sample_q   <= 1'b0;
      en_c0_n_q  <= 1'b1;
      row_n_q    <= '1;
      rowon_n_q  <= '1;
      rowoff_n_q <= '0;
      col_n_q    <= '1;
      en_bit_n_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      result_q   <= result_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      sample_q   <= (state_d == ST_SAMPLE);
      en_c0_n_q  <= !((state_d == ST_SAMPLE) || (state_d == ST_CONVERT));
      row_n_q    <= row_n_d;
      rowon_n_q  <= rowon_n_d;
      rowoff_n_q <= rowoff_n_d;
      col_n_q    <= col_n_d;
      en_bit_n_q <= ~code_d[2:0];
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign sample_o   = sample_q;
  assign sample_n_o = ~sample_q;
  assign sw_o       = sample_q;
  assign sw_n_o     = ~sample_q;
  assign row_n_o    = row_n_q;
  assign rowon_n_o  = rowon_n_q;
  assign rowoff_n_o = rowoff_n_q;
  assign col_n_o    = col_n_q;
  assign col_o      = ~col_n_q;
  assign en_bit_n_o = en_bit_n_q;
  assign en_C0_n_o  = en_c0_n_q;

endmodule
